// File: rtl/jesd204b_pkg.sv
// Shared definitions for the JESD204B per-lane 8b/10b encoder.
//   - Control-character constants and the list of legal K codes.
//   - enc_rec_t: per-octet lookup record registered by encoder stage 1.
//   - Helpers: K legality test and reordering into line bit order.
package jesd204b_pkg;

   localparam logic [7:0] K28_0 = 8'h1C;
   localparam logic [7:0] K28_3 = 8'h7C;  // /A/
   localparam logic [7:0] K28_4 = 8'h9C;  // /Q/
   localparam logic [7:0] K28_5 = 8'hBC;  // /K/
   localparam logic [7:0] K28_7 = 8'hFC;  // /F/

   localparam int unsigned NUM_LEGAL_K = 12;
   // K28.0..K28.7, K23.7, K27.7, K29.7, K30.7 (entry 0 is K28.0)
   localparam logic [NUM_LEGAL_K-1:0][7:0] LEGAL_K = {
      8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFC, 8'hDC,
      8'hBC, 8'h9C, 8'h7C, 8'h5C, 8'h3C, 8'h1C
   };

   // Codes are held in transmission notation: abcdei / fghj with a (or f) as MSB.
   // *_n is the alternative used when the running disparity entering it is RD-.
   typedef struct packed {
      logic [5:0] code6_n;
      logic [5:0] code6_p;
      logic [3:0] code4_n;  // D.x.7 holds P7 here; A7 is substituted in stage 2
      logic [3:0] code4_p;
      logic       unbal6;   // 6b subblock is +-2, so it flips RD
      logic       unbal4;   // 4b subblock is +-2, so it flips RD
      logic       a7_n;     // data x.7 that must use A7 when entering the 4b at RD-
      logic       a7_p;     // data x.7 that must use A7 when entering the 4b at RD+
      logic       is_k;
      logic       k_legal;
   } enc_rec_t;

   function automatic logic is_legal_k(input logic [7:0] oct);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_LEGAL_K; i++) begin
         if (oct == LEGAL_K[i]) hit = 1'b1;
      end
      return hit;
   endfunction

   // {abcdei,fghj} -> {j,h,g,f,i,e,d,c,b,a}: a full bit reversal puts a at the LSB.
   function automatic logic [9:0] to_line_order(input logic [5:0] c6, input logic [3:0] c4);
      logic [9:0] s;
      logic [9:0] r;
      s = {c6, c4};
      for (int i = 0; i < 10; i++) r[i] = s[9-i];
      return r;
   endfunction

endpackage

// File: rtl/jesd204b_enc8b10b_if.sv
// Lane bus between the data link TX / serializer and the 8b/10b encoder.
//   in/ctrl_in/in_valid : lane word, per-octet K flags and qualifier (octet 0 first)
//   out/out_valid       : 10-bit symbols, symbol k at out[10k+:10]
//   kerr                : per-octet illegal-K flag, aligned with out_valid
//   rd                  : running disparity after the last emitted word
// master drives the word side (link TX), slave is the encoder.
interface jesd204b_enc8b10b_if #(
   parameter int LANE_DATA_WIDTH = 32,
   parameter int OCTET_PER_SENT  = 4
);
   logic [LANE_DATA_WIDTH-1:0]   in;
   logic [OCTET_PER_SENT-1:0]    ctrl_in;
   logic                         in_valid;
   logic [10*OCTET_PER_SENT-1:0] out;
   logic                         out_valid;
   logic [OCTET_PER_SENT-1:0]    kerr;
   logic                         rd;

   modport master (
      output in, ctrl_in, in_valid,
      input  out, out_valid, kerr, rd
   );

   modport slave (
      input  in, ctrl_in, in_valid,
      output out, out_valid, kerr, rd
   );
endinterface

// File: rtl/jesd204b_enc8b10b_octet.sv
// Combinational per-octet 8b/10b lookup, independent of running disparity.
//   octet : input byte (HGF EDCBA)
//   is_k  : octet is flagged as a control character
//   rec   : both-polarity 6b/4b codes, disparity classes, A7 and K-legal flags
// An illegal K is looked up as K28.5 so the stream stays decodable.
module jesd204b_enc8b10b_octet
   import jesd204b_pkg::*;
(
   input  logic [7:0] octet,
   input  logic       is_k,
   output enc_rec_t   rec
);

   logic       legal;
   logic [7:0] oct;
   logic [4:0] x;
   logic [2:0] y;
   logic       k28;
   logic [5:0] c6;
   logic [3:0] c4;

   always_comb begin
      legal = is_legal_k(octet);
      oct   = (is_k && !legal) ? K28_5 : octet;
      x     = oct[4:0];
      y     = oct[7:5];
      k28   = is_k && (x == 5'd28);

      // 5b/6b, RD- alternative
      unique case (x)
         5'd0:  c6 = 6'b100111;  5'd1:  c6 = 6'b011101;  5'd2:  c6 = 6'b101101;
         5'd3:  c6 = 6'b110001;  5'd4:  c6 = 6'b110101;  5'd5:  c6 = 6'b101001;
         5'd6:  c6 = 6'b011001;  5'd7:  c6 = 6'b111000;  5'd8:  c6 = 6'b111001;
         5'd9:  c6 = 6'b100101;  5'd10: c6 = 6'b010101;  5'd11: c6 = 6'b110100;
         5'd12: c6 = 6'b001101;  5'd13: c6 = 6'b101100;  5'd14: c6 = 6'b011100;
         5'd15: c6 = 6'b010111;  5'd16: c6 = 6'b011011;  5'd17: c6 = 6'b100011;
         5'd18: c6 = 6'b010011;  5'd19: c6 = 6'b110010;  5'd20: c6 = 6'b001011;
         5'd21: c6 = 6'b101010;  5'd22: c6 = 6'b011010;  5'd23: c6 = 6'b111010;
         5'd24: c6 = 6'b110011;  5'd25: c6 = 6'b100110;  5'd26: c6 = 6'b010110;
         5'd27: c6 = 6'b110110;  5'd28: c6 = k28 ? 6'b001111 : 6'b001110;
         5'd29: c6 = 6'b101110;  5'd30: c6 = 6'b011110;
         default: c6 = 6'b101011;
      endcase

      // 3b/4b, RD- alternative (data column holds P7 for y=7)
      if (is_k) begin
         unique case (y)
            3'd0: c4 = 4'b1011;  3'd1: c4 = 4'b0110;  3'd2: c4 = 4'b1010;
            3'd3: c4 = 4'b1100;  3'd4: c4 = 4'b1101;  3'd5: c4 = 4'b0101;
            3'd6: c4 = 4'b1001;
            default: c4 = 4'b0111;
         endcase
      end else begin
         unique case (y)
            3'd0: c4 = 4'b1011;  3'd1: c4 = 4'b1001;  3'd2: c4 = 4'b0101;
            3'd3: c4 = 4'b1100;  3'd4: c4 = 4'b1101;  3'd5: c4 = 4'b1010;
            3'd6: c4 = 4'b0110;
            default: c4 = 4'b1110;
         endcase
      end

      rec.code6_n = c6;
      rec.unbal6  = ($countones(c6) != 3);
      // D.7 is neutral yet still alternates with RD
      rec.code6_p = (rec.unbal6 || (x == 5'd7)) ? ~c6 : c6;
      rec.code4_n = c4;
      rec.unbal4  = ($countones(c4) != 2);
      // Every K 4b code alternates; data only when unbalanced or x.3
      rec.code4_p = (is_k || rec.unbal4 || (y == 3'd3)) ? ~c4 : c4;
      rec.a7_n    = !is_k && (y == 3'd7) && (x inside {5'd17, 5'd18, 5'd20});
      rec.a7_p    = !is_k && (y == 3'd7) && (x inside {5'd11, 5'd13, 5'd14});
      rec.is_k    = is_k;
      rec.k_legal = legal;
   end

endmodule

// File: rtl/jesd204b_enc8b10b.sv
// JESD204B per-lane 8b/10b encoder, two-stage pipeline.
//   clk, reset : clock and synchronous active-high reset
//   bus        : lane interface (slave side); see jesd204b_enc8b10b_if
// Stage 1 registers the RD-independent per-octet lookups; stage 2 walks the
// running disparity through octets 0..N-1, picks each symbol and updates rd.
module jesd204b_enc8b10b
   import jesd204b_pkg::*;
#(
   parameter int LANE_DATA_WIDTH = 32,
   parameter int OCTET_PER_SENT  = 4
) (
   input logic                  clk,
   input logic                  reset,
   jesd204b_enc8b10b_if.slave   bus
);

   logic [LANE_DATA_WIDTH-1:0]                 in_word;
   enc_rec_t [OCTET_PER_SENT-1:0]              rec_d, rec_q;
   logic                                       s1_valid_q;

   logic [10*OCTET_PER_SENT-1:0]               out_d, out_q;
   logic [OCTET_PER_SENT-1:0]                  kerr_d, kerr_q;
   logic                                       rd_d, rd_q;
   logic                                       out_valid_q;

   logic [10*OCTET_PER_SENT-1:0]               sym_word;
   logic [OCTET_PER_SENT-1:0]                  kerr_word;
   logic                                       rd_run, rd_mid;
   logic [5:0]                                 c6;
   logic [3:0]                                 c4;

   assign in_word = bus.in;

   for (genvar k = 0; k < OCTET_PER_SENT; k++) begin : g_octet
      jesd204b_enc8b10b_octet u_octet (
         .octet (in_word[8*k +: 8]),
         .is_k  (bus.ctrl_in[k]),
         .rec   (rec_d[k])
      );
   end

   always_comb begin
      out_d     = out_q;
      kerr_d    = '0;
      rd_d      = rd_q;
      sym_word  = '0;
      kerr_word = '0;
      rd_run    = rd_q;
      rd_mid    = rd_q;
      c6        = '0;
      c4        = '0;
      for (int k = 0; k < OCTET_PER_SENT; k++) begin
         c6     = rd_run ? rec_q[k].code6_p : rec_q[k].code6_n;
         // 4b polarity follows the RD left by the 6b subblock
         rd_mid = rd_run ^ rec_q[k].unbal6;
         if (rd_mid) c4 = rec_q[k].a7_p ? 4'b1000 : rec_q[k].code4_p;
         else        c4 = rec_q[k].a7_n ? 4'b0111 : rec_q[k].code4_n;
         rd_run = rd_mid ^ rec_q[k].unbal4;
         sym_word[10*k +: 10] = to_line_order(c6, c4);
         kerr_word[k]         = rec_q[k].is_k && !rec_q[k].k_legal;
      end
      if (s1_valid_q) begin
         out_d  = sym_word;
         kerr_d = kerr_word;
         rd_d   = rd_run;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rec_q       <= '0;
         s1_valid_q  <= 1'b0;
         out_q       <= '0;
         kerr_q      <= '0;
         rd_q        <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         rec_q       <= rec_d;
         s1_valid_q  <= bus.in_valid;
         out_q       <= out_d;
         kerr_q      <= kerr_d;
         rd_q        <= rd_d;
         out_valid_q <= s1_valid_q;
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.kerr      = kerr_q;
   assign bus.rd        = rd_q;

endmodule

// File: tb/tb_jesd204b_enc8b10b.sv
// Self-checking bench for jesd204b_enc8b10b: directed cases with literal
// expected symbols, then randomized words against a behavioural encoder model
// that chooses each subblock alternative from its ones count and the RD.
module tb_jesd204b_enc8b10b;

   localparam int N = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   jesd204b_enc8b10b_if #(.LANE_DATA_WIDTH(32), .OCTET_PER_SENT(N)) bus ();

   jesd204b_enc8b10b #(.LANE_DATA_WIDTH(32), .OCTET_PER_SENT(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // RD- alternatives in transmission notation (a / f as MSB)
   logic [5:0] t6 [32] = '{
      6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
      6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
      6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
      6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
   };
   logic [3:0] t4d [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110,
                           4'b1110};
   logic [3:0] t4k [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001,
                           4'b0111};
   logic [7:0] kl [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
                           8'hF7, 8'hFB, 8'hFD, 8'hFE};

   // model state: stage-1 contents and the expected visible outputs
   logic        m_rd = 1'b0;
   logic        p1_v = 1'b0;
   logic [39:0] p1_o = '0;
   logic [3:0]  p1_k = '0;
   logic        p1_rd = 1'b0;
   logic        e_v = 1'b0;
   logic [39:0] e_o = '0;
   logic [3:0]  e_k = '0;
   logic        e_rd = 1'b0;

   logic [31:0] d;
   logic [3:0]  c;
   logic        v;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] want);
      n_chk++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, want);
   endtask

   function automatic logic legal_k(input logic [7:0] b);
      logic hit;
      hit = 1'b0;
      foreach (kl[i]) if (kl[i] == b) hit = 1'b1;
      return hit;
   endfunction

   task automatic enc_octet(input logic [7:0] b_in, input logic k, input logic rd_in,
                            output logic [9:0] sym, output logic rd_out, output logic ke);
      logic [7:0] b;
      logic [4:0] x;
      logic [2:0] y;
      logic [5:0] c6;
      logic [3:0] c4;
      logic       r6;
      logic [9:0] s;
      ke = k && !legal_k(b_in);
      b  = ke ? 8'hBC : b_in;
      x  = b[4:0];
      y  = b[7:5];
      c6 = (k && x == 5'd28) ? 6'b001111 : t6[x];
      // at RD+ the heavy (or the alternating D.7) code is replaced by its complement
      if (rd_in && ($countones(c6) > 3 || x == 5'd7)) c6 = ~c6;
      r6 = ($countones(c6) > 3) ? 1'b1 : ($countones(c6) < 3) ? 1'b0 : rd_in;
      c4 = k ? t4k[y] : t4d[y];
      if (!k && y == 3'd7 &&
          (r6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
              : (x == 5'd17 || x == 5'd18 || x == 5'd20))) c4 = 4'b0111;
      if (r6 && ($countones(c4) > 2 || y == 3'd3 || k)) c4 = ~c4;
      rd_out = ($countones(c4) > 2) ? 1'b1 : ($countones(c4) < 2) ? 1'b0 : r6;
      s = {c6, c4};
      for (int i = 0; i < 10; i++) sym[i] = s[9-i];
   endtask

   // Drive one cycle, advance the model past the edge, compare all outputs.
   task automatic cycle(input logic vi, input logic [31:0] di, input logic [3:0] ci,
                        input logic rst);
      logic       r, rn, ke;
      logic [9:0] s;
      reset        = rst;
      bus.in       = di;
      bus.ctrl_in  = ci;
      bus.in_valid = vi;
      @(posedge clk);
      #1;
      if (rst) begin
         p1_v = 1'b0; e_v = 1'b0; e_o = '0; e_k = '0; e_rd = 1'b0; m_rd = 1'b0;
      end else begin
         if (p1_v) begin
            e_v = 1'b1; e_o = p1_o; e_k = p1_k; e_rd = p1_rd;
         end else begin
            e_v = 1'b0; e_k = '0;
         end
         p1_v = vi;
         if (vi) begin
            r = m_rd;
            for (int k = 0; k < N; k++) begin
               enc_octet(di[8*k +: 8], ci[k], r, s, rn, ke);
               p1_o[10*k +: 10] = s;
               p1_k[k] = ke;
               r = rn;
            end
            p1_rd = r;
            m_rd  = r;
         end
      end
      check("out_valid", 64'(bus.out_valid), 64'(e_v));
      check("out", 64'(bus.out), 64'(e_o));
      check("kerr", 64'(bus.kerr), 64'(e_k));
      check("rd", 64'(bus.rd), 64'(e_rd));
   endtask

   initial begin
      cycle(1'b1, 32'hBCBCBCBC, 4'hF, 1'b1);
      cycle(1'b0, 32'h0, 4'h0, 1'b1);
      check("rst_out", 64'(bus.out), 64'd0);
      check("rst_rd", 64'(bus.rd), 64'd0);

      // K28.5 word from RD-
      cycle(1'b1, 32'hBCBCBCBC, 4'hF, 1'b0);
      cycle(1'b0, 32'h0, 4'h0, 1'b0);
      check("k285_sym", 64'(bus.out), 64'({10'h283, 10'h17C, 10'h283, 10'h17C}));
      check("k285_rd", 64'(bus.rd), 64'd0);
      check("k285_kerr", 64'(bus.kerr), 64'd0);

      // D21.5 from RD+, back to back with the word that sets RD+
      cycle(1'b1, 32'hB5B5B5BC, 4'h1, 1'b0);
      cycle(1'b1, 32'hB5B5B5B5, 4'h0, 1'b0);
      cycle(1'b0, 32'h0, 4'h0, 1'b0);
      check("d215_sym", 64'(bus.out), 64'({4{10'h155}}));
      check("d215_rd", 64'(bus.rd), 64'd1);

      // idle cycles hold out and rd
      repeat (3) cycle(1'b0, 32'h0, 4'h0, 1'b0);
      check("gap_rd", 64'(bus.rd), 64'd1);
      check("gap_out", 64'(bus.out), 64'({4{10'h155}}));

      // D0.0 from RD-
      cycle(1'b0, 32'h0, 4'h0, 1'b1);
      cycle(1'b1, 32'h00000000, 4'h0, 1'b0);
      cycle(1'b0, 32'h0, 4'h0, 1'b0);
      check("d00_sym", 64'(bus.out), 64'({4{10'h0B9}}));
      check("d00_rd", 64'(bus.rd), 64'd0);

      // illegal K in octet 0, K28.0 in octets 1..3
      cycle(1'b1, 32'h1C1C1C00, 4'hF, 1'b0);
      cycle(1'b0, 32'h0, 4'h0, 1'b0);
      check("illk_sym", 64'(bus.out), 64'({10'h343, 10'h343, 10'h343, 10'h17C}));
      check("illk_kerr", 64'(bus.kerr), 64'b0001);
      check("illk_valid", 64'(bus.out_valid), 64'd1);
      cycle(1'b0, 32'h0, 4'h0, 1'b0);
      check("illk_kerr_clr", 64'(bus.kerr), 64'd0);

      // gapped K28.5 words starting from RD+
      cycle(1'b1, 32'hBCBCBCBC, 4'hF, 1'b0);
      cycle(1'b0, 32'h0, 4'h0, 1'b0);
      cycle(1'b1, 32'hBCBCBCBC, 4'hF, 1'b0);
      cycle(1'b0, 32'h0, 4'h0, 1'b0);
      check("gap2_sym", 64'(bus.out), 64'({10'h17C, 10'h283, 10'h17C, 10'h283}));
      check("gap2_rd", 64'(bus.rd), 64'd1);

      // reset with two words in flight
      cycle(1'b1, 32'hB5B5B5BC, 4'h1, 1'b0);
      cycle(1'b1, 32'hB5B5B5BC, 4'h1, 1'b1);
      check("midrst_valid", 64'(bus.out_valid), 64'd0);
      cycle(1'b0, 32'h0, 4'h0, 1'b0);
      check("midrst_valid2", 64'(bus.out_valid), 64'd0);
      check("midrst_rd", 64'(bus.rd), 64'd0);
      cycle(1'b1, 32'hBCBCBCBC, 4'hF, 1'b0);
      cycle(1'b0, 32'h0, 4'h0, 1'b0);
      check("postrst_sym", 64'(bus.out), 64'({10'h283, 10'h17C, 10'h283, 10'h17C}));

      // random words, K flags restricted to legal codes
      for (int i = 0; i < 10000; i++) begin
         v = ($urandom_range(0, 9) != 0);
         d = $urandom;
         c = 4'($urandom);
         for (int k = 0; k < N; k++) begin
            if (c[k]) d[8*k +: 8] = kl[$urandom_range(0, 11)];
         end
         cycle(v, d, c, 1'b0);
      end

      // random words with arbitrary K bytes and occasional reset
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 3) != 0);
         d = $urandom;
         c = 4'($urandom);
         cycle(v, d, c, ($urandom_range(0, 49) == 0));
      end

      cycle(1'b0, 32'h0, 4'h0, 1'b0);
      cycle(1'b0, 32'h0, 4'h0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/jesd204b_enc8b10b.md
# jesd204b_enc8b10b

Per-lane 8b/10b encoder sitting directly downstream of the data link TX (`jesd204b_dl_tx`). It consumes one lane word of `OCTET_PER_SENT` octets plus per-octet control (K) flags each cycle and emits `OCTET_PER_SENT` 10-bit symbols to the serializer. Running disparity is chained across the octets of a word and carried between words. The block is a two-stage pipeline; one instance is used per lane.

## Interface
- `LANE_DATA_WIDTH`, 32: input word width; must equal 8*`OCTET_PER_SENT`.
- `OCTET_PER_SENT`, 4: octets per word.
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `in` in `LANE_DATA_WIDTH`: octet k at `in[8k+:8]`; octet 0 is first in time.
- `ctrl_in` in `OCTET_PER_SENT`: bit k=1 means octet k is a K character.
- `in_valid` in 1: word qualifier.
- `out` out 10*`OCTET_PER_SENT`: symbol k at `out[10k+:10]`, bit order {j,h,g,f,i,e,d,c,b,a}; a is the LSB and is sent first.
- `out_valid` out 1: `out` qualifier.
- `kerr` out `OCTET_PER_SENT`: bit k=1 means octet k was flagged K but is not a legal K code.
- `rd` out 1: running disparity after the last emitted word (0=RD−, 1=RD+).

## Operation
- **Stage 1** (registered, RD-independent), per octet:
  - 5b/6b and 3b/4b lookups for both RD polarities.
  - Subblock disparity class: neutral or ±2.
  - A7 eligibility: x∈{17,18,20} for RD−, x∈{11,13,14} for RD+.
  - K legality check.
- **Stage 2** (registered):
  - Resolve the RD chain octet 0→N−1, starting from the `rd` register.
  - The RD after the 6b subblock selects the 4b polarity. The RD after the 4b subblock feeds the next octet.
  - Select the final symbol and update `rd` from the last octet.
- **Legal K codes:** K28.0–K28.7 (0x1C,0x3C,…,0xFC), K23.7 (0xF7), K27.7 (0xFB), K29.7 (0xFD), K30.7 (0xFE).
  - K28.x uses the K 3b/4b table: x=1,2,5,6 use inverted alternatives.
  - Kx.7 uses the 1000/0111 encoding.
- **Illegal K** (ctrl=1, octet not in the list): encode as K28.5 at the current RD and set the `kerr` bit for that octet, aligned with `out_valid`.
- Data octets use the standard D tables. D.x.7 uses A7 when eligible, else P7.
- **`in_valid`=0:**
  - The bubble propagates and `out_valid`=0 two cycles later.
  - `rd` and `out` hold.
  - `kerr` is cleared to 0 on non-valid output cycles.
- **No backpressure:** the serializer always accepts.

## Timing
- Latency: in_valid/in at cycle n → `out_valid`/`out`/`kerr` at n+2. Throughput is one word per cycle.
- `rd` updates in the same cycle as the `out` it describes.
- **Reset values:** `out`=0, `out_valid`=0, `kerr`=0, `rd`=0 (RD−); stage-1 valid cleared.
- **Reset mid-stream:**
  - Both stages flush. Words in flight are dropped, never emitted.
  - The first word after deassertion encodes from RD−.
  - `in_valid` sampled in a cycle where `reset`=1 is ignored.
- **Back-to-back valid words:** the RD chain is continuous with no gap. The octet-0 RD of word m+1 equals the final RD of word m.
- **Gapped words:** RD is preserved across any number of invalid cycles.

## Structure
- Shared package `jesd204b_pkg`, holding:
  - K constants: K28_0=8'h1C, K28_3=8'h7C (/A/), K28_4=8'h9C (/Q/), K28_5=8'hBC (/K/), K28_7=8'hFC (/F/), plus the legal-K list.
  - Typedef for the stage-1 per-octet record: both-polarity 6b/4b codes, disparity flags, A7 flag, K-legal flag.
- Sub-module `jesd204b_enc8b10b_octet`: combinational per-octet lookup feeding stage 1, instantiated `OCTET_PER_SENT` times via generate. The RD chain and registers stay in the top module.

## Test plan
- **K28.5 from RD−:** after reset, one word in=32'hBCBCBCBC, ctrl=4'hF → two cycles later out={0x283,0x17C,0x283,0x17C} (octet 3..0), `rd`=0, `kerr`=0.
- **Neutral data:** in=32'hB5B5B5B5, ctrl=0 from RD+ (preceded by a single K28.5 word with ctrl=4'h1) → every symbol 0x155, `rd` unchanged at 1.
- **Neutral D0.0 word:** in=32'h00000000, ctrl=0 from RD− → every symbol 0x0B9, `rd`=0.
- **Illegal K:** in=32'h1C1C1C00, ctrl=4'hF from RD− → symbol 0=0x17C, `kerr`=4'b0001, symbols 1–3 are K28.0 with the RD chain continued, `out_valid`=1.
- **Gapped stream and reset:**
  - Valid/invalid/valid K28.5 words → `rd` held across the gap; the second word starts from the RD left by the first.
  - Assert `reset` with two words in flight → neither word emitted, `out_valid`=0, `rd`=0.
- **Random regression:** 10k random words with random ctrl restricted to legal K → decode with a reference 8b/10b decoder: zero code errors, zero disparity errors, data and K flags match, latency exactly 2.
